// File: rtl/io_in_port.sv
// rtl/io_in_port.sv - CPU input port: producer handshake into a small FIFO, bus-side read/pop and status
//
// Purpose
//   This is the world-to-CPU input port. An external producer pushes bytes
//   over a valid/ready handshake into a DEPTH-entry FIFO. The CPU reads the
//   head byte or a status byte through the combinational bus mux, and pops
//   the head with rd_en.
//
// Optional feature (macro IO_IN_OVERRUN_EN)
//   When defined, a sticky overrun flag records a byte the producer offered
//   while the port was not ready. A status read clears the flag. When
//   undefined, status bit 2 reads 0.
//
// Parameters
//   DEPTH  FIFO entries; power of two, at least 2
//   WIDTH  data width; 8 for the CPU bus low byte
//
// Ports
//   clk          in   gated CPU clock; all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   ext_data     in   producer byte
//   ext_valid    in   producer offers ext_data
//   ext_ready    out  port can accept (!full && !rst)
//   out_en       in   drive head byte on out
//   stat_out_en  in   drive status byte on out (lower priority than out_en)
//   rd_en        in   pop head at this edge
//   out          out  bus source value; 0 when no enable is high
//   empty        out  FIFO holds no entries
//   full         out  FIFO holds DEPTH entries

module io_in_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ext_valid,
  output logic             ext_ready,
  input  logic             out_en,
  input  logic             stat_out_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_overrun;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_status;

  // Flags come from the registered count only, so ext_ready has no
  // combinational path from ext_valid.
  assign empty     = (r_count == '0);
  assign full      = (r_count == L_FULL);
  assign ext_ready = !full && !rst;

  // ext_ready already folds in rst and full, so a push in reset or into a
  // full FIFO is dropped. That holds even when the same edge pops.
  assign w_push = ext_valid && ext_ready;
  assign w_pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + L_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: slots beyond count are never presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= ext_data;
    end
  end

`ifdef IO_IN_OVERRUN_EN
  logic r_overrun;
  logic w_ovr_set;
  logic w_ovr_clr;

  // A byte offered while not ready is lost. A set on the same edge as a
  // status read wins, so that loss is still reported.
  assign w_ovr_set = ext_valid && !ext_ready && !rst;
  assign w_ovr_clr = stat_out_en && !out_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (w_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_overrun = r_overrun;
`else
  assign w_overrun = 1'b0;
`endif

  assign w_head   = empty ? '0 : r_mem[r_rptr];
  assign w_status = {{(WIDTH-3){1'b0}}, w_overrun, full, empty};

  // Bus mux shows pre-edge state. A read-and-pop returns the byte being
  // popped.
  always_comb begin
    out = '0;
    if (out_en) begin
      out = w_head;
    end else if (stat_out_en) begin
      out = w_status;
    end
  end

endmodule

// File: tb/tb_io_in_port.sv
// tb/tb_io_in_port.sv - directed plus random checks of io_in_port against a queue model
module tb_io_in_port;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ext_data = 8'h00;
  logic       ext_valid = 1'b0;
  logic       ext_ready;
  logic       out_en = 1'b0;
  logic       stat_out_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dut_out;
  logic       empty;
  logic       full;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: buffered bytes in arrival order, plus the sticky overrun bit.
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  bit         model_valid = 1'b0;
  logic [7:0] obs_out;

  io_in_port #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .ext_data(ext_data),
    .ext_valid(ext_valid),
    .ext_ready(ext_ready),
    .out_en(out_en),
    .stat_out_en(stat_out_en),
    .rd_en(rd_en),
    .out(dut_out),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, then advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic oe,
                       input logic soe, input logic re, input logic rs);
    logic [7:0] exp_out;
    logic [7:0] exp_stat;
    logic       can_push;
    int         n;
    ext_valid   = v;
    ext_data    = d;
    out_en      = oe;
    stat_out_en = soe;
    rd_en       = re;
    rst         = rs;
    @(negedge clk);
    n        = q.size();
    can_push = (n < DEPTH) && !rs;
`ifdef IO_IN_OVERRUN_EN
    exp_stat = {5'b0, m_ovr, n == DEPTH, n == 0};
`else
    exp_stat = {5'b0, 1'b0, n == DEPTH, n == 0};
`endif
    if (oe)       exp_out = (n == 0) ? 8'h00 : q[0];
    else if (soe) exp_out = exp_stat;
    else          exp_out = 8'h00;
    obs_out = dut_out;
    if (model_valid) begin
      check("ext_ready", {7'b0, ext_ready}, {7'b0, can_push});
      check("empty", {7'b0, empty}, {7'b0, n == 0});
      check("full", {7'b0, full}, {7'b0, n == DEPTH});
      check("out", dut_out, exp_out);
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovr = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (re && n > 0) void'(q.pop_front());
      if (v && n < DEPTH) q.push_back(d);
      if (v && n == DEPTH) m_ovr = 1'b1;
      else if (soe && !oe) m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic stat_read();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_ovr_stat;

    // Reset
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    stat_read();
    check("reset_status", obs_out, 8'h01);

    // In-order delivery
    push(8'h11);
    push(8'h22);
    push(8'h33);
    read_pop(); check("seq0", obs_out, 8'h11);
    read_pop(); check("seq1", obs_out, 8'h22);
    read_pop(); check("seq2", obs_out, 8'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("seq_empty_out", obs_out, 8'h00);
    check("seq_empty_flag", {7'b0, empty}, 8'h01);

    // Fill, status, pop one, refill, then drain across wrap-around
    for (int i = 0; i < DEPTH; i++) push(8'hA0 + 8'(i));
    stat_read(); check("full_status", obs_out, 8'h02);
    check("full_not_ready", {7'b0, ext_ready}, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    push(8'hA4);
    for (int i = 1; i <= 4; i++) begin
      read_pop();
      check("wrap_drain", obs_out, 8'hA0 + 8'(i));
    end

    // Steady-state push and pop with two entries buffered
    push(8'hB0);
    push(8'hB1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'hB2 + 8'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      check("stream", obs_out, 8'hB0 + 8'(i));
    end
    read_pop(); check("stream_tail0", obs_out, 8'hBA);
    read_pop(); check("stream_tail1", obs_out, 8'hBB);

    // Pop on empty with a simultaneous push: only the push takes effect
    cycle(1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_pop_push", obs_out, 8'h5C);
    read_pop();

    // Producer ignores backpressure for one cycle
    for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i));
    push(8'hEE);
`ifdef IO_IN_OVERRUN_EN
    exp_ovr_stat = 8'h06;
`else
    exp_ovr_stat = 8'h02;
`endif
    stat_read(); check("overrun_status", obs_out, exp_ovr_stat);
    stat_read(); check("overrun_cleared", obs_out, 8'h02);
    for (int i = 0; i < DEPTH; i++) begin
      read_pop();
      check("overrun_contents", obs_out, 8'hC0 + 8'(i));
    end

    // Reset with bytes buffered and a push pending
    push(8'hD0);
    push(8'hD1);
    push(8'hD2);
    cycle(1'b1, 8'hD3, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_out", obs_out, 8'h00);
    check("post_reset_empty", {7'b0, empty}, 8'h01);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 59) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_in_port.md
# io_in_port

Input-port peripheral for the 8-bit CPU: the world-to-CPU counterpart of the ALU output latch. It accepts bytes from an external producer over a valid/ready handshake and buffers them in a small FIFO. It presents the head byte, or a status byte, to the CPU bus under controller enables, and pops the head on a controller read strobe. It sits on the bus mux alongside the regfile, ALU and memory sources and is clocked by the gated CPU clock.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- WIDTH, 8, data width; fixed to the 8-bit bus low byte.

- clk  in  1  CPU clock (gated clock output); all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ext_data  in  WIDTH  producer byte.
- ext_valid  in  1  producer has a byte on ext_data.
- ext_ready  out  1  port can accept; equals !full && !rst.
- out_en  in  1  controller: drive head byte on out.
- stat_out_en  in  1  controller: drive status byte on out; lower priority than out_en.
- rd_en  in  1  controller: pop head at this edge.
- out  out  WIDTH  bus source value; 0x00 when neither enable is high.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.

## Operation
- Storage: DEPTH×WIDTH array, write pointer, read pointer (log2(DEPTH) bits, natural wrap), count (log2(DEPTH)+1 bits).
- Push: ext_valid && ext_ready at the edge. Writes ext_data at wptr, wptr+1, count+1.
- Pop: rd_en && !empty at the edge. rptr+1, count-1. rd_en while empty is ignored, with no state change.
- Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
- When full, ext_ready is low, so no push occurs even if rd_en pops in the same cycle. There is no full-bypass.
- When empty, a push together with rd_en results in push only; the pop is ignored.
- out mux, combinational:
  - out_en high: head byte (array[rptr]); 0x00 if empty.
  - Otherwise stat_out_en high: status byte {5'b0, overrun, full, empty}.
  - Otherwise: 0x00.
- The data and the status read reflect pre-edge state. A pop in the same cycle as out_en returns the byte being popped, which is the standard read-and-pop instruction.
- Reset, synchronous: wptr=rptr=count=0, overrun=0. Array contents are don't-care. Outputs during and after reset: empty=1, full=0, ext_ready=0 while rst is high and 1 afterwards, out=0x00 unless an enable is high. Reset mid-transfer discards buffered bytes, and a push coinciding with rst is dropped.

## Timing
- Push to visible at head: 1 cycle. A byte pushed at edge N is readable with out_en in cycle N+1; empty falls at edge N.
- ext_ready updates the cycle after the count changes. It is combinational from registered count only, with no path from ext_valid.
- Pop affects out at the next edge. out has zero latency from out_en and stat_out_en (combinational mux).
- Throughput: one push and one pop per cycle.
- When clk is halted (hlt), no state changes. The producer must hold ext_valid and ext_data until the handshake completes.

## Configuration
- IO_IN_OVERRUN_EN:
  - Defined: sticky overrun bit. Set at any edge where ext_valid && !ext_ready && !rst, meaning the producer ignored backpressure and the byte is lost. Cleared at an edge where stat_out_en && !out_en (status read). Set wins if both occur at the same edge. Reported at status bit 2.
  - Undefined: no overrun register; status bit 2 reads 0.

## Test plan
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles, then read with out_en+rd_en each cycle. out must show 0x11, 0x22, 0x33 in order, empty=1 after the third pop, and a fourth out_en must give 0x00.
- Fill with DEPTH=4 bytes 0xA0..0xA3: full=1, ext_ready=0, status=0x02. Pop once: ext_ready=1 the next cycle, and a push of 0xA4 is accepted. Drain order must be A1, A2, A3, A4 (wrap-around).
- With 2 entries, push and pop every cycle for 10 cycles: count holds at 2, and data order is preserved across pointer wrap.
- rd_en on an empty FIFO with a simultaneous push of 0x5C: no underflow, count=1, and the next out_en gives 0x5C.
- Full FIFO, ext_valid held for one cycle. With IO_IN_OVERRUN_EN: status=0x06, and a status read clears it to 0x02. Without the macro: status=0x02 throughout, and FIFO contents are unchanged in both builds.
- Assert rst for one cycle with 3 entries buffered and a push pending: empty=1, ext_ready=0 during reset, and the pushed byte is absent afterwards.
